vga_reg_exec: RTL and testbench



---
 rtl/vga_regs_pkg.sv | 30 +++
 rtl/vga_cursor_ctr.sv | 44 ++++
 rtl/vga_reg_exec.sv | 154 +++++++++++++++
 tb/tb_vga_reg_exec.sv | 197 +++++++++++++++++++
 4 files changed

// File: rtl/vga_regs_pkg.sv
// Shared definitions for the VGA text controller register executor:
// command codes, register bit positions, defaults and state encoding.
package vga_regs_pkg;

  localparam logic [7:0] CMD_STATUS = 8'h00;
  localparam logic [7:0] CMD_DATA   = 8'h01;
  localparam logic [7:0] CMD_CUR    = 8'h02;
  localparam logic [7:0] CMD_CUR_H  = 8'h03;
  localparam logic [7:0] CMD_CTRL   = 8'h04;

  localparam int unsigned CTRL_VIS   = 0;
  localparam int unsigned CTRL_BLINK = 1;
  localparam int unsigned CTRL_AUTO  = 2;
  localparam int unsigned CTRL_CLR   = 7;

  localparam int unsigned STS_READY = 0;
  localparam int unsigned STS_BUSY  = 1;
  localparam int unsigned STS_WRAP  = 2;
  localparam int unsigned STS_BAD   = 3;
  localparam int unsigned STS_OVR   = 4;

  localparam logic [7:0] CLR_CHAR_DEF = 8'h20;
  localparam logic [6:0] CTRL_RST     = 7'h07;

  typedef enum logic {
    S_IDLE,
    S_CLEAR
  } state_e;

endpackage

// File: rtl/vga_cursor_ctr.sv
// Cursor cell register: clear, range-checked load, and increment with
// wrap at the last cell of the screen.
module vga_cursor_ctr #(
  parameter int unsigned COLS  = 80,
  parameter int unsigned ROWS  = 30,
  parameter int unsigned ADR_W = 12
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_clr,
  input  logic             i_load,
  input  logic [ADR_W-1:0] i_load_val,
  input  logic             i_inc,
  output logic [ADR_W-1:0] o_cursor,
  output logic             o_wrap,
  output logic             o_bad
);

  localparam logic [ADR_W-1:0] LAST = ADR_W'(COLS * ROWS - 1);

  logic [ADR_W-1:0] cursor_q, cursor_d;

  assign o_bad  = i_load && (i_load_val > LAST);
  assign o_wrap = i_inc && !i_load && !i_clr && (cursor_q == LAST);

  always_comb begin
    cursor_d = cursor_q;
    if (i_clr) begin
      cursor_d = '0;
    end else if (i_load) begin
      cursor_d = o_bad ? '0 : i_load_val;
    end else if (i_inc) begin
      cursor_d = o_wrap ? '0 : cursor_q + 1'b1;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) cursor_q <= '0;
    else          cursor_q <= cursor_d;
  end

  assign o_cursor = cursor_q;

endmodule

// File: rtl/vga_reg_exec.sv
// Register/command executor for the VGA text controller: decodes strobes
// from the SPI front-end, owns cursor/ctrl/status and runs clear-screen.
module vga_reg_exec
  import vga_regs_pkg::*;
#(
  parameter int unsigned COLS     = 80,
  parameter int unsigned ROWS     = 30,
  parameter int unsigned ADR_W    = 12,
  parameter logic [7:0]  CLR_CHAR = CLR_CHAR_DEF
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic [7:0]       i_vga_cmd,
  input  logic [ADR_W-1:0] i_vga_cur_adr,
  input  logic [7:0]       i_vga_port,
  output logic [7:0]       o_vga_port,
  input  logic             i_vga_cs_h,
  input  logic             i_vga_rl_wh,
  output logic             o_vga_ready_h,
  output logic             o_ram_we,
  output logic [ADR_W-1:0] o_ram_adr,
  output logic [7:0]       o_ram_wdata,
  output logic [ADR_W-1:0] o_cursor,
  output logic [7:0]       o_ctrl
);

  localparam logic [ADR_W-1:0] LAST = ADR_W'(COLS * ROWS - 1);

  state_e           state_q, state_d;
  logic [6:0]       ctrl_q, ctrl_d;
  logic [2:0]       stk_q, stk_d;    // {overrun, bad cursor, wrap}
  logic [7:0]       port_q, port_d;
  logic             ram_we_q, ram_we_d;
  logic [ADR_W-1:0] ram_adr_q, ram_adr_d;
  logic [7:0]       ram_wdata_q, ram_wdata_d;
  logic [ADR_W-1:0] clr_cnt_q, clr_cnt_d;

  logic             idle, busy, wr_acc, rd_acc;
  logic             cur_clr, cur_load, cur_inc, cur_wrap, cur_bad;
  logic [ADR_W-1:0] cursor;
  logic [7:0]       status_rd;

  assign idle      = (state_q == S_IDLE);
  assign busy      = (state_q == S_CLEAR);
  assign wr_acc    = idle && i_vga_cs_h && i_vga_rl_wh;
  assign rd_acc    = idle && i_vga_cs_h && !i_vga_rl_wh;
  assign status_rd = {3'b000, stk_q, busy, idle};

  // Cursor controls kept outside the main decode so the wrap/bad flags
  // fed back from the counter do not form a combinational block loop.
  assign cur_load = wr_acc && (i_vga_cmd == CMD_CUR);
  assign cur_inc  = wr_acc && (i_vga_cmd == CMD_DATA) && ctrl_q[CTRL_AUTO];
  assign cur_clr  = busy && (clr_cnt_q == LAST);

  vga_cursor_ctr #(
    .COLS  (COLS),
    .ROWS  (ROWS),
    .ADR_W (ADR_W)
  ) u_cursor (
    .i_clk      (i_clk),
    .i_rst_n    (i_rst_n),
    .i_clr      (cur_clr),
    .i_load     (cur_load),
    .i_load_val (i_vga_cur_adr),
    .i_inc      (cur_inc),
    .o_cursor   (cursor),
    .o_wrap     (cur_wrap),
    .o_bad      (cur_bad)
  );

  always_comb begin
    state_d     = state_q;
    ctrl_d      = ctrl_q;
    stk_d       = stk_q;
    port_d      = port_q;
    ram_we_d    = 1'b0;
    ram_adr_d   = ram_adr_q;
    ram_wdata_d = ram_wdata_q;
    clr_cnt_d   = clr_cnt_q;

    case (state_q)
      S_IDLE: begin
        if (wr_acc) begin
          case (i_vga_cmd)
            CMD_DATA: begin
              ram_we_d    = 1'b1;
              ram_adr_d   = cursor;
              ram_wdata_d = i_vga_port;
              if (cur_wrap) stk_d[0] = 1'b1;
            end
            CMD_CUR: if (cur_bad) stk_d[1] = 1'b1;
            CMD_CTRL: begin
              ctrl_d = i_vga_port[6:0];
              if (i_vga_port[CTRL_CLR]) begin
                state_d   = S_CLEAR;
                clr_cnt_d = '0;
              end
            end
            CMD_STATUS: stk_d = stk_q & ~i_vga_port[STS_OVR:STS_WRAP];
            default: ;
          endcase
        end else if (rd_acc) begin
          case (i_vga_cmd)
            CMD_STATUS: port_d = status_rd;
            CMD_CUR:    port_d = 8'(cursor);
            CMD_CUR_H:  port_d = 8'(cursor >> 8);
            CMD_CTRL:   port_d = {busy, ctrl_q};
            default: ;
          endcase
        end
      end
      S_CLEAR: begin
        ram_we_d    = 1'b1;
        ram_adr_d   = clr_cnt_q;
        ram_wdata_d = CLR_CHAR;
        clr_cnt_d   = clr_cnt_q + 1'b1;
        if (clr_cnt_q == LAST) state_d = S_IDLE;
        if (i_vga_cs_h) stk_d[2] = 1'b1;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q     <= S_IDLE;
      ctrl_q      <= CTRL_RST;
      stk_q       <= '0;
      port_q      <= '0;
      ram_we_q    <= 1'b0;
      ram_adr_q   <= '0;
      ram_wdata_q <= '0;
      clr_cnt_q   <= '0;
    end else begin
      state_q     <= state_d;
      ctrl_q      <= ctrl_d;
      stk_q       <= stk_d;
      port_q      <= port_d;
      ram_we_q    <= ram_we_d;
      ram_adr_q   <= ram_adr_d;
      ram_wdata_q <= ram_wdata_d;
      clr_cnt_q   <= clr_cnt_d;
    end
  end

  assign o_vga_port    = port_q;
  assign o_vga_ready_h = idle;
  assign o_ram_we      = ram_we_q;
  assign o_ram_adr     = ram_adr_q;
  assign o_ram_wdata   = ram_wdata_q;
  assign o_cursor      = cursor;
  assign o_ctrl        = {busy, ctrl_q};

endmodule

// File: tb/tb_vga_reg_exec.sv
// Directed self-checking bench for vga_reg_exec (80x30 screen, 12-bit cells).
module tb_vga_reg_exec;

  logic        i_clk = 1'b0;
  logic        i_rst_n = 1'b0;
  logic [7:0]  i_vga_cmd = '0;
  logic [11:0] i_vga_cur_adr = '0;
  logic [7:0]  i_vga_port = '0;
  logic [7:0]  o_vga_port;
  logic        i_vga_cs_h = 1'b0;
  logic        i_vga_rl_wh = 1'b0;
  logic        o_vga_ready_h;
  logic        o_ram_we;
  logic [11:0] o_ram_adr;
  logic [7:0]  o_ram_wdata;
  logic [11:0] o_cursor;
  logic [7:0]  o_ctrl;

  int n_cmp = 0;
  int n_err = 0;

  vga_reg_exec #(
    .COLS     (80),
    .ROWS     (30),
    .ADR_W    (12),
    .CLR_CHAR (8'h20)
  ) dut (
    .i_clk         (i_clk),
    .i_rst_n       (i_rst_n),
    .i_vga_cmd     (i_vga_cmd),
    .i_vga_cur_adr (i_vga_cur_adr),
    .i_vga_port    (i_vga_port),
    .o_vga_port    (o_vga_port),
    .i_vga_cs_h    (i_vga_cs_h),
    .i_vga_rl_wh   (i_vga_rl_wh),
    .o_vga_ready_h (o_vga_ready_h),
    .o_ram_we      (o_ram_we),
    .o_ram_adr     (o_ram_adr),
    .o_ram_wdata   (o_ram_wdata),
    .o_cursor      (o_cursor),
    .o_ctrl        (o_ctrl)
  );

  always #5 i_clk = ~i_clk;

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One-cycle strobe; returns #1 after the accepting edge.
  task automatic strobe(input logic [7:0] cmd, input logic wr, input logic [7:0] data,
                        input logic [11:0] adr);
    @(posedge i_clk); #1;
    i_vga_cmd = cmd; i_vga_rl_wh = wr; i_vga_port = data; i_vga_cur_adr = adr;
    i_vga_cs_h = 1'b1;
    @(posedge i_clk); #1;
    i_vga_cs_h = 1'b0;
  endtask

  task automatic rd(input logic [7:0] cmd, input string tag, input logic [7:0] exp);
    strobe(cmd, 1'b0, 8'h00, 12'h000);
    check(tag, {8'h00, o_vga_port}, {8'h00, exp});
  endtask

  initial begin : main
    int  n_wr;
    bit  order_ok;
    bit  injected;
    bit  hit;

    // Reset state
    repeat (3) @(posedge i_clk);
    #1;
    check("rst_ready", 16'(o_vga_ready_h), 16'h1);
    check("rst_cursor", 16'(o_cursor), 16'h0);
    check("rst_ram_we", 16'(o_ram_we), 16'h0);
    check("rst_port", 16'(o_vga_port), 16'h0);
    check("rst_ctrl_out", 16'(o_ctrl), 16'h07);
    i_rst_n = 1'b1;
    rd(8'h00, "rst_status", 8'h01);
    rd(8'h04, "rst_ctrl_rd", 8'h07);

    // Cursor load and auto-increment DATA writes
    strobe(8'h02, 1'b1, 8'h00, 12'h12C);
    check("cur_load", 16'(o_cursor), 16'h12C);
    strobe(8'h01, 1'b1, 8'h41, 12'h000);
    check("d1_we", 16'(o_ram_we), 16'h1);
    check("d1_adr", 16'(o_ram_adr), 16'h12C);
    check("d1_data", 16'(o_ram_wdata), 16'h41);
    check("d1_ready", 16'(o_vga_ready_h), 16'h1);
    strobe(8'h01, 1'b1, 8'h42, 12'h000);
    check("d2_adr", 16'(o_ram_adr), 16'h12D);
    check("d2_data", 16'(o_ram_wdata), 16'h42);
    @(posedge i_clk); #1;
    check("d2_we_pulse", 16'(o_ram_we), 16'h0);
    rd(8'h02, "cur_l", 8'h2E);
    rd(8'h03, "cur_h", 8'h01);

    // Wrap at the last cell
    strobe(8'h02, 1'b1, 8'h00, 12'd2399);
    strobe(8'h01, 1'b1, 8'h58, 12'h000);
    check("wrap_adr", 16'(o_ram_adr), 16'd2399);
    check("wrap_data", 16'(o_ram_wdata), 16'h58);
    check("wrap_cursor", 16'(o_cursor), 16'h0);
    rd(8'h00, "wrap_status", 8'h05);
    strobe(8'h00, 1'b1, 8'h04, 12'h000);
    rd(8'h00, "w1c_status", 8'h01);

    // Out-of-range cursor load
    strobe(8'h02, 1'b1, 8'h00, 12'd3000);
    check("bad_cursor", 16'(o_cursor), 16'h0);
    rd(8'h00, "bad_status", 8'h09);

    // Auto-increment off: repeated writes hit the same cell
    strobe(8'h04, 1'b1, 8'h03, 12'h000);
    check("ctrl_wr", 16'(o_ctrl), 16'h03);
    strobe(8'h02, 1'b1, 8'h00, 12'd5);
    strobe(8'h01, 1'b1, 8'h30, 12'h000);
    check("noinc1_adr", 16'(o_ram_adr), 16'd5);
    strobe(8'h01, 1'b1, 8'h31, 12'h000);
    check("noinc2_adr", 16'(o_ram_adr), 16'd5);
    check("noinc2_data", 16'(o_ram_wdata), 16'h31);
    check("noinc_cursor", 16'(o_cursor), 16'd5);

    // Unknown command is ignored
    strobe(8'h05, 1'b1, 8'hFF, 12'h000);
    check("badcmd_ctrl", 16'(o_ctrl), 16'h03);
    check("badcmd_cursor", 16'(o_cursor), 16'd5);
    strobe(8'h00, 1'b1, 8'h1C, 12'h000);
    rd(8'h00, "clr_sticky", 8'h01);

    // Clear-screen fill with an overrun strobe mid-fill
    strobe(8'h02, 1'b1, 8'h00, 12'h010);
    strobe(8'h04, 1'b1, 8'h83, 12'h000);
    check("clr_ready_low", 16'(o_vga_ready_h), 16'h0);
    n_wr = 0; order_ok = 1'b1; injected = 1'b0;
    for (int c = 0; c < 3000; c++) begin
      @(posedge i_clk); #1;
      i_vga_cs_h = 1'b0;
      if (o_ram_we) begin
        if (o_ram_adr != 12'(n_wr) || o_ram_wdata != 8'h20) order_ok = 1'b0;
        n_wr++;
      end
      if (o_vga_ready_h) break;
      if (n_wr == 500 && !injected) begin
        i_vga_cmd = 8'h01; i_vga_rl_wh = 1'b1; i_vga_port = 8'hEE;
        i_vga_cs_h = 1'b1; injected = 1'b1;
      end
    end
    check("clr_ready_back", 16'(o_vga_ready_h), 16'h1);
    check("clr_count", 16'(n_wr), 16'd2400);
    check("clr_order", 16'(order_ok), 16'h1);
    check("clr_cursor", 16'(o_cursor), 16'h0);
    rd(8'h00, "clr_status", 8'h11);
    rd(8'h04, "clr_ctrl", 8'h03);

    // Reset mid-clear at cell 1000
    strobe(8'h04, 1'b1, 8'h87, 12'h000);
    hit = 1'b0;
    for (int c = 0; c < 3000; c++) begin
      @(posedge i_clk); #1;
      if (o_ram_we && o_ram_adr == 12'd1000) begin
        hit = 1'b1;
        break;
      end
    end
    check("reach_1000", 16'(hit), 16'h1);
    i_rst_n = 1'b0;
    #1;
    check("rst_mid_we", 16'(o_ram_we), 16'h0);
    check("rst_mid_adr", 16'(o_ram_adr), 16'h0);
    check("rst_mid_ready", 16'(o_vga_ready_h), 16'h1);
    check("rst_mid_ctrl", 16'(o_ctrl), 16'h07);
    check("rst_mid_port", 16'(o_vga_port), 16'h0);
    repeat (3) @(posedge i_clk);
    #2;
    i_rst_n = 1'b1;
    n_wr = 0;
    for (int c = 0; c < 30; c++) begin
      @(posedge i_clk); #1;
      if (o_ram_we) n_wr++;
    end
    check("post_rst_writes", 16'(n_wr), 16'h0);
    check("post_rst_ready", 16'(o_vga_ready_h), 16'h1);
    check("post_rst_cursor", 16'(o_cursor), 16'h0);
    rd(8'h00, "post_rst_status", 8'h01);
    rd(8'h04, "post_rst_ctrl", 8'h07);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
